// File: rtl/pulse_trigger_gen.sv
// Edge-triggered pulse train generator: optional start delay, then either a
// fixed burst of pulses (one-shot) or a train that runs while 'on' stays high.
module pulse_trigger_gen #(
    parameter int W = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         on,
    input  logic         mode,
    input  logic [W-1:0] delay,
    input  logic [W-1:0] high_len,
    input  logic [W-1:0] low_len,
    input  logic [W-1:0] count,
    output logic         signal,
    output logic         busy,
    output logic         done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DELAY = 2'd1,
        HIGH  = 2'd2,
        LOW   = 2'd3
    } state_t;

    state_t       state_q, state_d;
    logic         on_q;
    logic [W-1:0] cnt_q, cnt_d;
    logic [W-1:0] pulse_q, pulse_d;
    logic [W-1:0] high_q, high_d;
    logic [W-1:0] low_q, low_d;
    logic         mode_q, mode_d;
    logic         stop_q, stop_d;
    logic         done_q, done_d;
    logic         trigger;
    logic         last_high;

    function automatic logic [W-1:0] at_least_one(input logic [W-1:0] v);
        return (v == '0) ? W'(1) : v;
    endfunction

    assign trigger = on & ~on_q;
    assign signal  = (state_q == HIGH);
    assign busy    = (state_q != IDLE);
    assign done    = done_q;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            on_q    <= 1'b0;
            cnt_q   <= '0;
            pulse_q <= '0;
            high_q  <= '0;
            low_q   <= '0;
            mode_q  <= 1'b0;
            stop_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            on_q    <= on;
            cnt_q   <= cnt_d;
            pulse_q <= pulse_d;
            high_q  <= high_d;
            low_q   <= low_d;
            mode_q  <= mode_d;
            stop_q  <= stop_d;
            done_q  <= done_d;
        end
    end

    // A continuous train that sees 'on' low during HIGH remembers it in
    // stop_q so the high phase still runs its full length before stopping.
    always_comb begin
        last_high = mode_q ? (stop_q | ~on) : (pulse_q == W'(1));
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        pulse_d = pulse_q;
        high_d  = high_q;
        low_d   = low_q;
        mode_d  = mode_q;
        stop_d  = stop_q;
        done_d  = 1'b0;

        case (state_q)
            IDLE: begin
                if (trigger) begin
                    mode_d  = mode;
                    high_d  = at_least_one(high_len);
                    low_d   = at_least_one(low_len);
                    pulse_d = at_least_one(count);
                    stop_d  = 1'b0;
                    if (delay != '0) begin
                        state_d = DELAY;
                        cnt_d   = delay - W'(1);
                    end else begin
                        state_d = HIGH;
                        cnt_d   = at_least_one(high_len) - W'(1);
                    end
                end
            end
            DELAY: begin
                if (mode_q && !on) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = high_q - W'(1);
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            HIGH: begin
                if (mode_q && !on) begin
                    stop_d = 1'b1;
                end
                if (cnt_q == '0) begin
                    if (last_high) begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                        stop_d  = 1'b0;
                    end else begin
                        state_d = LOW;
                        cnt_d   = low_q - W'(1);
                        if (!mode_q) begin
                            pulse_d = pulse_q - W'(1);
                        end
                    end
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            LOW: begin
                if (mode_q && !on) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (cnt_q == '0) begin
                    state_d = HIGH;
                    cnt_d   = high_q - W'(1);
                end else begin
                    cnt_d = cnt_q - W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pulse_trigger_gen.sv
// Scoreboard bench for pulse_trigger_gen: each scenario queues the expected
// {signal,busy,done} per cycle after the trigger edge and compares on negedge.
module tb_pulse_trigger_gen;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         reset;
    logic         on;
    logic         mode;
    logic [W-1:0] delay;
    logic [W-1:0] high_len;
    logic [W-1:0] low_len;
    logic [W-1:0] count;
    logic         signal;
    logic         busy;
    logic         done;

    int n_tests = 0;
    int n_fail  = 0;
    logic [2:0] exp_q[$];

    pulse_trigger_gen #(.W(W)) dut (
        .clock    (clock),
        .reset    (reset),
        .on       (on),
        .mode     (mode),
        .delay    (delay),
        .high_len (high_len),
        .low_len  (low_len),
        .count    (count),
        .signal   (signal),
        .busy     (busy),
        .done     (done)
    );

    always #5 clock = ~clock;

    // Expected one-shot waveform: delay cycles, pulses separated by lows,
    // no trailing low, then the done cycle.
    function automatic void push_oneshot(int d, int h, int l, int c);
        int hh = (h == 0) ? 1 : h;
        int ll = (l == 0) ? 1 : l;
        int cc = (c == 0) ? 1 : c;
        for (int i = 0; i < d; i++) exp_q.push_back(3'b010);
        for (int p = 0; p < cc; p++) begin
            for (int i = 0; i < hh; i++) exp_q.push_back(3'b110);
            if (p != cc - 1)
                for (int i = 0; i < ll; i++) exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b001);
    endfunction

    function automatic void push_idle(int n);
        for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
    endfunction

    task automatic settle_idle();
        on = 1'b0;
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic test_reset();
        logic [2:0] got;
        reset = 1'b1; on = 1'b0; mode = 1'b0;
        delay = '0; high_len = '0; low_len = '0; count = '0;
        #1;
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_async: got %b want 000", got);
        end
        repeat (2) @(posedge clock);
        @(negedge clock);
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_held: got %b want 000", got);
        end
        reset = 1'b0;
        @(posedge clock);
        @(negedge clock);
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_release_idle: got %b want 000", got);
        end
    endtask

    task automatic test_oneshot();
        int cyc = 0;
        logic [2:0] exp;
        mode = 1'b0; delay = 8'd3; high_len = 8'd2; low_len = 8'd1; count = 8'd3;
        push_oneshot(3, 2, 1, 3);
        push_idle(2);
        on = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL oneshot cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
        end
        settle_idle();
    endtask

    task automatic test_zero_settings();
        int cyc = 0;
        logic [2:0] exp;
        mode = 1'b0; delay = '0; high_len = '0; low_len = '0; count = '0;
        push_oneshot(0, 0, 0, 0);
        push_idle(2);
        on = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL zero cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
        end
        settle_idle();
    endtask

    task automatic test_retrigger();
        int cyc = 0;
        logic [2:0] exp;
        mode = 1'b0; delay = 8'd3; high_len = 8'd2; low_len = 8'd1; count = 8'd3;
        push_oneshot(3, 2, 1, 3);
        push_oneshot(3, 2, 1, 3);
        push_idle(2);
        on = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL retrigger cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
            if (cyc == 3 || cyc == 11) on = 1'b0;
            if (cyc == 5 || cyc == 12) on = 1'b1;
        end
        settle_idle();
    endtask

    task automatic test_continuous();
        int cyc = 0;
        logic [2:0] exp;
        mode = 1'b1; delay = '0; high_len = 8'd1; low_len = 8'd1; count = '0;
        for (int i = 0; i < 4; i++) begin
            exp_q.push_back(3'b110);
            exp_q.push_back(3'b010);
        end
        exp_q.push_back(3'b110);
        exp_q.push_back(3'b001);
        push_idle(1);
        on = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL continuous cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
            if (cyc == 9) on = 1'b0;
        end
        mode = 1'b0;
        settle_idle();
    endtask

    // Continuous stop cases: 0 = drop mid-HIGH, 1 = drop in LOW, 2 = drop in DELAY.
    task automatic test_cont_stop();
        int d_tab[3]    = '{0, 0, 4};
        int h_tab[3]    = '{3, 1, 1};
        int l_tab[3]    = '{1, 3, 1};
        int drop_tab[3] = '{1, 2, 2};
        for (int k = 0; k < 3; k++) begin
            int cyc = 0;
            logic [2:0] exp;
            mode = 1'b1;
            delay = W'(d_tab[k]); high_len = W'(h_tab[k]); low_len = W'(l_tab[k]); count = '0;
            case (k)
                0: begin
                    repeat (3) exp_q.push_back(3'b110);
                end
                1: begin
                    exp_q.push_back(3'b110);
                    exp_q.push_back(3'b010);
                end
                default: begin
                    repeat (2) exp_q.push_back(3'b010);
                end
            endcase
            exp_q.push_back(3'b001);
            push_idle(1);
            on = 1'b1;
            while (exp_q.size() > 0) begin
                @(posedge clock);
                @(negedge clock);
                cyc++;
                exp = exp_q.pop_front();
                n_tests++;
                if ({signal, busy, done} !== exp) begin
                    n_fail++;
                    $display("FAIL cont_stop case %0d cyc %0d: got %b want %b", k, cyc, {signal, busy, done}, exp);
                end
                if (cyc == drop_tab[k]) on = 1'b0;
            end
            settle_idle();
        end
        mode = 1'b0;
    endtask

    task automatic test_mid_reset();
        int cyc = 0;
        logic [2:0] exp;
        logic [2:0] got;
        mode = 1'b0; delay = '0; high_len = 8'd5; low_len = 8'd1; count = 8'd1;
        on = 1'b1;
        @(posedge clock);
        @(negedge clock);
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b110) begin
            n_fail++;
            $display("FAIL midreset_pre: got %b want 110", got);
        end
        @(posedge clock);
        #2;
        reset = 1'b1;
        #1;
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_async: got %b want 000", got);
        end
        @(posedge clock);
        @(negedge clock);
        got = {signal, busy, done};
        n_tests++;
        if (got !== 3'b000) begin
            n_fail++;
            $display("FAIL midreset_held: got %b want 000", got);
        end
        reset = 1'b0;
        push_oneshot(0, 5, 1, 1);
        push_idle(2);
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL midreset_restart cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
        end
        settle_idle();
    endtask

    task automatic test_config_latch();
        int cyc = 0;
        logic [2:0] exp;
        mode = 1'b0; delay = 8'd2; high_len = 8'd2; low_len = 8'd2; count = 8'd2;
        push_oneshot(2, 2, 2, 2);
        push_idle(1);
        push_oneshot(255, 255, 255, 2);
        push_idle(2);
        on = 1'b1;
        while (exp_q.size() > 0) begin
            @(posedge clock);
            @(negedge clock);
            cyc++;
            exp = exp_q.pop_front();
            n_tests++;
            if ({signal, busy, done} !== exp) begin
                n_fail++;
                $display("FAIL config_latch cyc %0d: got %b want %b", cyc, {signal, busy, done}, exp);
            end
            if (cyc == 1) begin
                delay = 8'd255; high_len = 8'd255; low_len = 8'd255;
            end
            if (cyc == 2) count = 8'd2;
            if (cyc == 3) on = 1'b0;
            if (cyc == 10) on = 1'b1;
        end
        settle_idle();
    endtask

    initial begin
        test_reset();
        test_oneshot();
        test_zero_settings();
        test_retrigger();
        test_continuous();
        test_cont_stop();
        test_mid_reset();
        test_config_latch();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/pulse_trigger_gen.md
PULSE_TRIGGER_GEN -- requirements
Module: pulse_trigger_gen

Interface
REQ-001 Parameter: W, default 8, width of all timing and count fields and internal counters.
REQ-002 Port: clock  input  1  single clock; all state changes on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: on  input  1  trigger request; the rising edge starts a sequence, and the level sustains continuous mode.
REQ-005 Port: mode  input  1  0 = one-shot burst of count pulses; 1 = continuous while on stays high.
REQ-006 Port: delay  input  W  cycles between trigger and first pulse.
REQ-007 Port: high_len  input  W  cycles signal stays high per pulse; 0 is treated as 1.
REQ-008 Port: low_len  input  W  cycles signal stays low between pulses; 0 is treated as 1.
REQ-009 Port: count  input  W  pulses per one-shot burst; 0 is treated as 1; ignored when mode=1.
REQ-010 Port: signal  output  1  pulse train output.
REQ-011 Port: busy  output  1  high whenever state is not IDLE.
REQ-012 Port: done  output  1  one-cycle completion strobe.

Function
REQ-013 Edge detect: a registered copy on_q SHALL be kept; trigger = on & ~on_q, sampled at a clock edge E0.
REQ-014 FSM states SHALL be IDLE, DELAY, HIGH and LOW; signal = (state==HIGH), decoded from the state register only.
REQ-015 At E0 in IDLE: mode, delay, high_len, low_len and count SHALL be latched; the next state is DELAY if delay!=0, else HIGH.
REQ-016 DELAY SHALL last exactly delay cycles, HIGH exactly max(high_len,1) cycles, and LOW exactly max(low_len,1) cycles; one W-bit down-counter SHALL time all phases.
REQ-017 With delay=d, signal SHALL first be high in the (d+1)th cycle after E0.
REQ-018 One-shot: a W-bit pulse counter SHALL track pulses; after the last HIGH, the FSM SHALL go directly to IDLE with no trailing LOW; otherwise HIGH SHALL be followed by LOW, then HIGH.
REQ-019 Continuous: HIGH/LOW SHALL alternate while on=1; on=0 sampled in DELAY or LOW SHALL go to IDLE at that edge; on=0 sampled in HIGH SHALL complete the HIGH phase, then go to IDLE.
REQ-020 done SHALL be registered and high for exactly the first IDLE cycle after any completed sequence; it SHALL NOT assert on reset.
REQ-021 Trigger edges while busy SHALL be ignored; no queueing and no restart.
REQ-022 Input changes while busy SHALL have no effect on the current sequence, except on in continuous mode.
REQ-023 Input changes SHALL NOT wrap: all counters count down and stop at terminal value; max(2^W-1) settings SHALL be honoured exactly.
REQ-024 A trigger in the same cycle as done (IDLE) SHALL start a new sequence normally.

Reset
REQ-025 reset=1 SHALL immediately (asynchronously) force state=IDLE, signal=0, busy=0, done=0, on_q=0, and all counters and latched configuration to 0.
REQ-026 Reset asserted mid-sequence SHALL abort it without a done strobe.
REQ-027 After reset release, an on level already high SHALL count as a rising edge at the first clock edge.

Verification
REQ-028 Case 1 (one-shot timing): W=8, mode=0, delay=3, high_len=2, low_len=1, count=3; on rises at E0 -> signal per cycle after E0: 0,0,0,1,1,0,1,1,0,1,1; busy for those 11 cycles; done=1 in cycle 12 only.
REQ-029 Case 2 (zero settings): delay=0, high_len=0, low_len=0, count=0 -> single 1-cycle pulse in cycle 1 after E0; done in cycle 2; busy exactly 1 cycle.
REQ-030 Case 3 (retrigger ignored): during case 1, toggle on 0->1 at cycle 5 -> waveform identical to case 1; a new edge at the done cycle starts a fresh sequence.
REQ-031 Case 4 (continuous stop): mode=1, delay=0, high_len=1, low_len=1; hold on for 8 cycles -> signal alternates 1,0,...; on drops while in HIGH -> HIGH completes, IDLE next, done 1 cycle; on dropping while in LOW -> IDLE at that edge.
REQ-032 Case 5 (mid-sequence reset): reset pulse during a HIGH phase -> signal, busy and done=0 before the next clock edge; no done afterwards; with on held high, a new sequence starts at the first edge after release.
REQ-033 Case 6 (config latch): change delay/high_len/count during busy -> current burst unchanged; next trigger uses the new values; max values (255) give exact cycle counts.
